// File: rtl/imm_issue_scheduler.sv
// Dual-slot issue scheduler: holds one decoded pair, splits it on intra-pair
// RAW / memory-port / control-flow conflicts, and drives sign-extender lane controls.
module imm_issue_scheduler #(
  parameter int unsigned SPLIT_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0][4:0]        in_op_code,
  input  logic [1:0][31:0]       in_imm,
  input  logic [1:0]             in_imm_unsigned,
  input  logic [1:0][4:0]        in_rd,
  input  logic [1:0][4:0]        in_rs1,
  input  logic [1:0][4:0]        in_rs2,
  input  logic                   out_ready,
  output logic [1:0]             out_valid,
  output logic [1:0][4:0]        out_op_code,
  output logic [1:0][31:0]       out_imm,
  output logic [1:0]             sx_en,
  output logic [1:0]             sx_type,
  output logic [SPLIT_CNT_W-1:0] split_count
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BOTH  = 2'd1,
    S_SLOT1 = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0][4:0]        op_q, op_d;
  logic [1:0][31:0]       imm_q, imm_d;
  logic [1:0]             uns_q, uns_d;
  logic [1:0][4:0]        rd_q, rd_d;
  logic [1:0][4:0]        rs1_q, rs1_d;
  logic [1:0][4:0]        rs2_q, rs2_d;
  logic [SPLIT_CNT_W-1:0] cnt_q, cnt_d;

  logic split;
  logic last_issue;

  function automatic logic uses_rs1(input logic [4:0] op);
    return !((op[2:0] == 3'b101) || (op == 5'b11011));
  endfunction

  function automatic logic uses_rs2(input logic [4:0] op);
    return (op == 5'b01100) || (op == 5'b01000) || (op == 5'b11000);
  endfunction

  function automatic logic is_mem(input logic [4:0] op);
    return (op == 5'b00000) || (op == 5'b01000);
  endfunction

  function automatic logic is_ctrl(input logic [4:0] op);
    return (op == 5'b11000) || ((op[4:2] == 3'b110) && op[0]);
  endfunction

  function automatic logic ext_en(input logic [4:0] op);
    return (op[2:0] == 3'b101) || (op == 5'b00100) || (op == 5'b00000) ||
           (op == 5'b01000) || (op == 5'b11000) || ((op[4:2] == 3'b110) && op[0]);
  endfunction

  function automatic logic ext_uns_class(input logic [4:0] op);
    return (op == 5'b00100) || (op == 5'b00000) || (op == 5'b11000);
  endfunction

  always_comb begin
    split = ((rd_q[0] != 5'd0) &&
             ((uses_rs1(op_q[1]) && (rs1_q[1] == rd_q[0])) ||
              (uses_rs2(op_q[1]) && (rs2_q[1] == rd_q[0])))) ||
            (is_mem(op_q[0]) && is_mem(op_q[1])) ||
            is_ctrl(op_q[0]);
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    imm_d       = imm_q;
    uns_d       = uns_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    cnt_d       = cnt_q;
    out_valid   = '0;
    out_op_code = '0;
    out_imm     = '0;
    sx_en       = '0;
    sx_type     = '0;

    case (state_q)
      S_BOTH:  out_valid = split ? 2'b01 : 2'b11;
      S_SLOT1: out_valid = 2'b10;
      default: out_valid = 2'b00;
    endcase

    last_issue = out_ready && (((state_q == S_BOTH) && !split) || (state_q == S_SLOT1));
    in_ready   = !rst && !flush && ((state_q == S_EMPTY) || last_issue);

    if (rst) begin
      state_d = S_EMPTY;
      cnt_d   = '0;
    end else if (flush) begin
      state_d = S_EMPTY;
    end else begin
      if ((state_q == S_BOTH) && out_ready) begin
        state_d = split ? S_SLOT1 : S_EMPTY;
        if (split && (cnt_q != '1))
          cnt_d = cnt_q + SPLIT_CNT_W'(1);
      end
      if ((state_q == S_SLOT1) && out_ready)
        state_d = S_EMPTY;
      // Acceptance overrides the final-issue transition so pairs stream without a bubble.
      if (in_valid && in_ready) begin
        state_d = S_BOTH;
        op_d    = in_op_code;
        imm_d   = in_imm;
        uns_d   = in_imm_unsigned;
        rd_d    = in_rd;
        rs1_d   = in_rs1;
        rs2_d   = in_rs2;
      end
    end

    if (out_valid[0]) begin
      out_op_code[0] = op_q[0];
      out_imm[0]     = imm_q[0];
      sx_en[0]       = ext_en(op_q[0]);
      sx_type[0]     = ext_uns_class(op_q[0]) && uns_q[0];
    end
    if (out_valid[1]) begin
      out_op_code[1] = op_q[1];
      out_imm[1]     = imm_q[1];
      sx_en[1]       = ext_en(op_q[1]);
      sx_type[1]     = ext_uns_class(op_q[1]) && uns_q[1];
    end
  end

  assign split_count = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      op_q    <= '0;
      imm_q   <= '0;
      uns_q   <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      uns_q   <= uns_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_issue_scheduler.sv
// Directed bench for imm_issue_scheduler: pending-lane-mask model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_imm_issue_scheduler;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_ready;
  logic [1:0][4:0] in_op_code, in_rd, in_rs1, in_rs2;
  logic [1:0][31:0] in_imm;
  logic [1:0]      in_imm_unsigned;
  logic [1:0]      out_valid, sx_en, sx_type;
  logic [1:0][4:0] out_op_code;
  logic [1:0][31:0] out_imm;
  logic [CW-1:0]   split_count;

  int checks = 0;
  int errors = 0;

  imm_issue_scheduler #(.SPLIT_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op_code(in_op_code), .in_imm(in_imm), .in_imm_unsigned(in_imm_unsigned),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .out_ready(out_ready),
    .out_valid(out_valid), .out_op_code(out_op_code), .out_imm(out_imm),
    .sx_en(sx_en), .sx_type(sx_type), .split_count(split_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the held pair plus a mask of lanes still waiting to issue.
  bit        m_live = 0;
  bit [1:0]  m_pend;
  bit [4:0]  m_op[2], m_rd[2], m_rs1[2], m_rs2[2];
  bit [31:0] m_imm[2];
  bit        m_uns[2];
  int        m_cnt;

  function automatic bit reads_rs1(input bit [4:0] op);
    return !((op % 8 == 5) || op == 5'b11011);
  endfunction
  function automatic bit reads_rs2(input bit [4:0] op);
    return op inside {5'b01100, 5'b01000, 5'b11000};
  endfunction
  function automatic bit m_split();
    bit raw, mem, ctl;
    raw = (m_rd[0] != 0) && ((reads_rs1(m_op[1]) && m_rs1[1] == m_rd[0]) ||
                             (reads_rs2(m_op[1]) && m_rs2[1] == m_rd[0]));
    mem = (m_op[0] inside {5'b00000, 5'b01000}) && (m_op[1] inside {5'b00000, 5'b01000});
    ctl = m_op[0] inside {5'b11000, 5'b11001, 5'b11011};
    return raw || mem || ctl;
  endfunction
  function automatic bit [1:0] m_valid();
    if (m_pend == 2'b11) return m_split() ? 2'b01 : 2'b11;
    return m_pend;
  endfunction
  function automatic bit m_en(input bit [4:0] op);
    return (op % 8 == 5) || (op inside {5'b00100, 5'b00000, 5'b01000, 5'b11000, 5'b11001, 5'b11011});
  endfunction
  function automatic bit m_type(input bit [4:0] op, input bit u);
    return u && (op inside {5'b00100, 5'b00000, 5'b11000});
  endfunction
  function automatic bit m_in_ready();
    bit [1:0] iss;
    iss = out_ready ? m_valid() : 2'b00;
    return !rst && !flush && ((m_pend & ~iss) == 2'b00);
  endfunction

  always @(posedge clk) begin
    bit [1:0] iss;
    bit       acc;
    if (rst) begin
      m_live = 1;
      m_pend = 2'b00;
      m_cnt  = 0;
    end else if (m_live) begin
      iss = out_ready ? m_valid() : 2'b00;
      acc = in_valid && m_in_ready();
      if (flush) m_pend = 2'b00;
      else begin
        if (m_pend == 2'b11 && iss == 2'b01 && m_cnt < CMAX) m_cnt++;
        m_pend = m_pend & ~iss;
        if (acc) begin
          m_pend = 2'b11;
          for (int k = 0; k < 2; k++) begin
            m_op[k] = in_op_code[k]; m_imm[k] = in_imm[k]; m_uns[k] = in_imm_unsigned[k];
            m_rd[k] = in_rd[k]; m_rs1[k] = in_rs1[k]; m_rs2[k] = in_rs2[k];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    bit [1:0] v;
    if (m_live) begin
      v = m_valid();
      chk("out_valid", 32'(out_valid), 32'(v));
      chk("in_ready", 32'(in_ready), 32'(rst ? 1'b0 : m_in_ready()));
      chk("split_count", 32'(split_count), 32'(m_cnt));
      for (int k = 0; k < 2; k++) begin
        chk("out_op_code", 32'(out_op_code[k]), v[k] ? 32'(m_op[k]) : 32'd0);
        chk("out_imm", out_imm[k], v[k] ? m_imm[k] : 32'd0);
        chk("sx_en", 32'(sx_en[k]), v[k] ? 32'(m_en(m_op[k])) : 32'd0);
        chk("sx_type", 32'(sx_type[k]), v[k] ? 32'(m_type(m_op[k], m_uns[k])) : 32'd0);
      end
    end
  end

  task automatic cyc(input logic r, input logic f, input logic v, input logic o);
    rst = r; flush = f; in_valid = v; out_ready = o;
    @(posedge clk);
    #1;
  endtask

  task automatic pair(input logic [4:0] op0, input logic [31:0] imm0, input logic u0,
                      input logic [4:0] rd0, input logic [4:0] a0, input logic [4:0] b0,
                      input logic [4:0] op1, input logic [31:0] imm1, input logic u1,
                      input logic [4:0] rd1, input logic [4:0] a1, input logic [4:0] b1);
    in_op_code = {op1, op0}; in_imm = {imm1, imm0}; in_imm_unsigned = {u1, u0};
    in_rd = {rd1, rd0}; in_rs1 = {a1, a0}; in_rs2 = {b1, b0};
  endtask

  task automatic raw_pair();
    pair(5'b00100, 32'h10, 1'b0, 5'd5, 5'd1, 5'd0, 5'b01100, 32'h0, 1'b0, 5'd6, 5'd7, 5'd5);
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 0;
    pair('0, '0, 0, '0, '0, '0, '0, '0, 0, '0, '0, '0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_split_count", 32'(split_count), 0);
    rst = 0; #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // Independent addi + lui
    pair(5'b00100, 32'hFFF, 1'b0, 5'd1, 5'd2, 5'd0, 5'b01101, 32'h12345000, 1'b0, 5'd3, 5'd0, 5'd0);
    cyc(0, 0, 1, 1);
    chk("indep_valid", 32'(out_valid), 32'h3);
    chk("indep_sx_en", 32'(sx_en), 32'h3);
    chk("indep_sx_type", 32'(sx_type), 0);
    chk("indep_imm0", out_imm[0], 32'hFFF);
    chk("indep_in_ready", 32'(in_ready), 1);
    cyc(0, 0, 0, 1);
    chk("indep_done", 32'(out_valid), 0);

    // RAW via rs2
    raw_pair();
    cyc(0, 0, 1, 1);
    chk("raw_valid0", 32'(out_valid), 32'h1);
    chk("raw_in_ready", 32'(in_ready), 0);
    cyc(0, 0, 0, 1);
    chk("raw_valid1", 32'(out_valid), 32'h2);
    chk("raw_sx_en1", 32'(sx_en), 32'h0);
    chk("raw_count", 32'(split_count), 1);
    cyc(0, 0, 0, 1);

    // Load + store with 3-cycle stall
    pair(5'b00000, 32'h4, 1'b0, 5'd7, 5'd1, 5'd0, 5'b01000, 32'h8, 1'b0, 5'd0, 5'd8, 5'd9);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      chk("mem_stall_valid", 32'(out_valid), 32'h1);
      cyc(0, 0, 0, 0);
    end
    chk("mem_stall_valid", 32'(out_valid), 32'h1);
    cyc(0, 0, 0, 1);
    chk("mem_slot1", 32'(out_valid), 32'h2);
    chk("mem_count", 32'(split_count), 2);
    cyc(0, 0, 0, 1);

    // Branch with unsigned immediate, then back-to-back third pair
    pair(5'b11000, 32'h800, 1'b1, 5'd0, 5'd1, 5'd2, 5'b00100, 32'h7, 1'b0, 5'd4, 5'd3, 5'd0);
    cyc(0, 0, 1, 1);
    chk("br_valid", 32'(out_valid), 32'h1);
    chk("br_sx_type", 32'(sx_type), 32'h1);
    cyc(0, 0, 0, 1);
    pair(5'b00100, 32'hABC, 1'b1, 5'd10, 5'd1, 5'd0, 5'b00000, 32'h20, 1'b0, 5'd12, 5'd11, 5'd0);
    chk("br_b2b_in_ready", 32'(in_ready), 1);
    cyc(0, 0, 1, 1);
    chk("b2b_valid", 32'(out_valid), 32'h3);
    chk("b2b_sx_type", 32'(sx_type), 32'h1);
    chk("b2b_count", 32'(split_count), 3);
    cyc(0, 0, 0, 1);

    // Flush in SLOT1 with a pair offered
    raw_pair();
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    pair(5'b00100, 32'h55, 1'b0, 5'd1, 5'd0, 5'd0, 5'b00100, 32'h66, 1'b0, 5'd2, 5'd0, 5'd0);
    cyc(0, 1, 1, 1);
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_imm", out_imm[0] | out_imm[1], 0);
    cyc(0, 0, 0, 1);
    chk("flush_not_captured", 32'(out_valid), 0);
    // Flush during a split issue is not counted
    raw_pair();
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 1);
    chk("flush_count", 32'(split_count), 4);

    // Saturation
    for (int i = 0; i < CMAX + 2; i++) begin
      raw_pair();
      cyc(0, 0, 1, 1);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
    end
    chk("sat_count", 32'(split_count), 15);

    // No-op style pair: rd0 = 0 and rs1_1 = 0 must not split
    pair(5'b00100, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'b00100, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    cyc(0, 0, 1, 0);
    chk("nop_valid", 32'(out_valid), 32'h3);
    cyc(0, 0, 0, 1);

    // Reset mid-pair
    raw_pair();
    cyc(0, 0, 1, 0);
    cyc(1, 0, 1, 1);
    chk("rst_mid_valid", 32'(out_valid), 0);
    chk("rst_mid_count", 32'(split_count), 0);
    chk("rst_mid_sx", 32'({sx_en, sx_type}), 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
